// File: rtl/d_write_buffer.sv
// Coalescing line write buffer between a data cache and a single-ported memory.
// Optional macro WB_READ_FORWARD_EN: read hits are served from the buffer instead of waiting for a drain.
module d_write_buffer #(
    parameter int DEPTH       = 4,
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_write,
    input  logic [15:0] c_waddr,
    input  logic [63:0] c_wdata,
    output logic        c_wready,
    input  logic        c_read,
    input  logic [15:0] c_raddr,
    output logic [63:0] c_rdata,
    output logic        c_rvalid,
    output logic        m_readM,
    output logic        m_writeM,
    output logic [15:0] m_address,
    output logic [63:0] m_wdata,
    input  logic [63:0] m_rdata
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t      state_r;
    logic [13:0] addr_r [DEPTH];
    logic [63:0] data_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic [LW-1:0] lat_r;
    logic        c_wready_r;
    logic        c_rvalid_r;
    logic [63:0] c_rdata_r;
    logic        m_readm_r;
    logic        m_writem_r;
    logic [15:0] m_address_r;
    logic [63:0] m_wdata_r;

    logic          wr_acc_s;
    logic          read_pend_s;
    logic          coal_s;
    logic [PW-1:0] coal_idx_s;
    logic          hit_s;
    logic [63:0]   hit_data_s;
    logic [63:0]   head_wdata_s;
    logic          push_s;
    logic          pop_s;
    logic          fwd_s;
    logic          go_read_s;
    logic [CW-1:0] count_nxt_s;
    logic          unused_s;

    function automatic logic [13:0] line_of(input logic [15:0] addr);
        return addr[15:2];
    endfunction

    assign unused_s = ^{c_waddr[1:0], c_raddr[1:0]};

    // Entry matching: coalesce target for the incoming write and youngest hit for the read.
    always_comb begin
        logic [PW-1:0] idx_v;
        idx_v       = '0;
        wr_acc_s    = c_write && c_wready_r;
        read_pend_s = c_read && !c_rvalid_r;
        coal_s      = 1'b0;
        coal_idx_s  = '0;
        hit_s       = 1'b0;
        hit_data_s  = 64'd0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_v = head_r + PW'(k);
            if (CW'(k) < count_r) begin
                if (wr_acc_s && (addr_r[idx_v] == line_of(c_waddr)) &&
                    !((state_r == WRITE) && (k == 0))) begin
                    coal_s     = 1'b1;
                    coal_idx_s = idx_v;
                end else begin
                    coal_s     = coal_s;
                end
                // Iterating oldest to youngest leaves the youngest match in hit_data_s.
                if (addr_r[idx_v] == line_of(c_raddr)) begin
                    hit_s      = 1'b1;
                    hit_data_s = data_r[idx_v];
                end else begin
                    hit_s      = hit_s;
                end
            end else begin
                idx_v = idx_v;
            end
        end
        if (wr_acc_s && (line_of(c_waddr) == line_of(c_raddr))) begin
            hit_s      = 1'b1;
            hit_data_s = c_wdata;
        end else begin
            hit_s      = hit_s;
        end
        // A write coalescing into the head on the launch edge must reach memory.
        if (coal_s && (coal_idx_s == head_r)) begin
            head_wdata_s = c_wdata;
        end else begin
            head_wdata_s = data_r[head_r];
        end
        push_s      = wr_acc_s && !coal_s;
        pop_s       = (state_r == WRITE) && (lat_r == LW'(MEM_LATENCY - 1));
        count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
        go_read_s   = read_pend_s && !hit_s;
`ifdef WB_READ_FORWARD_EN
        fwd_s       = read_pend_s && hit_s && (state_r != READ);
`else
        fwd_s       = 1'b0;
`endif
    end

    // Queue storage, occupancy, memory-side FSM and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= 14'd0;
                data_r[i] <= 64'd0;
            end
            head_r      <= '0;
            tail_r      <= '0;
            count_r     <= '0;
            lat_r       <= '0;
            state_r     <= IDLE;
            c_wready_r  <= 1'b1;
            c_rvalid_r  <= 1'b0;
            c_rdata_r   <= 64'd0;
            m_readm_r   <= 1'b0;
            m_writem_r  <= 1'b0;
            m_address_r <= 16'd0;
            m_wdata_r   <= 64'd0;
        end else begin
            count_r    <= count_nxt_s;
            c_wready_r <= (count_nxt_s < CW'(DEPTH));
            if (push_s) begin
                addr_r[tail_r] <= line_of(c_waddr);
                data_r[tail_r] <= c_wdata;
                tail_r         <= tail_r + PW'(1);
            end
            if (coal_s) begin
                data_r[coal_idx_s] <= c_wdata;
            end
            if (pop_s) begin
                head_r <= head_r + PW'(1);
            end
            if (fwd_s) begin
                c_rvalid_r <= 1'b1;
                c_rdata_r  <= hit_data_s;
            end else begin
                c_rvalid_r <= 1'b0;
                c_rdata_r  <= 64'd0;
            end
            case (state_r)
                IDLE: begin
                    lat_r <= '0;
                    if (go_read_s) begin
                        state_r     <= READ;
                        m_readm_r   <= 1'b1;
                        m_address_r <= {line_of(c_raddr), 2'b00};
                    end else if (count_r != '0) begin
                        state_r     <= WRITE;
                        m_writem_r  <= 1'b1;
                        m_address_r <= {addr_r[head_r], 2'b00};
                        m_wdata_r   <= head_wdata_s;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                WRITE: begin
                    if (pop_s) begin
                        state_r     <= IDLE;
                        m_writem_r  <= 1'b0;
                        m_address_r <= 16'd0;
                        m_wdata_r   <= 64'd0;
                    end else begin
                        lat_r       <= lat_r + LW'(1);
                    end
                end
                READ: begin
                    if (lat_r == LW'(MEM_LATENCY - 1)) begin
                        state_r     <= IDLE;
                        m_readm_r   <= 1'b0;
                        m_address_r <= 16'd0;
                        c_rvalid_r  <= 1'b1;
                        c_rdata_r   <= m_rdata;
                    end else begin
                        lat_r       <= lat_r + LW'(1);
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    m_readm_r   <= 1'b0;
                    m_writem_r  <= 1'b0;
                    m_address_r <= 16'd0;
                    m_wdata_r   <= 64'd0;
                end
            endcase
        end
    end

    assign c_wready  = c_wready_r;
    assign c_rvalid  = c_rvalid_r;
    assign c_rdata   = c_rdata_r;
    assign m_readM   = m_readm_r;
    assign m_writeM  = m_writem_r;
    assign m_address = m_address_r;
    assign m_wdata   = m_wdata_r;

endmodule

// File: doc/d_write_buffer.md
D_WRITE_BUFFER -- requirements
Module: d_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of line entries, a power of two, at least 2.
REQ-002 Parameter MEM_LATENCY, default 4: memory cycles per line read or write, at least 1.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 c_write  in  1  data cache requests a line write.
REQ-006 c_waddr  in  16  word address of the write; bits [1:0] are ignored (line = 4 words).
REQ-007 c_wdata  in  64  line write data.
REQ-008 c_wready  out  1  high when the buffer is not full.
REQ-009 c_read  in  1  line read request, held high until c_rvalid.
REQ-010 c_raddr  in  16  word address of the read; bits [1:0] are ignored.
REQ-011 c_rdata  out  64  line read data.
REQ-012 c_rvalid  out  1  one-cycle pulse; c_rdata is valid in that cycle.
REQ-013 m_readM, m_writeM  out  1 each  memory read and write strobes.
REQ-014 m_address  out  16  memory line address, with bits [1:0] = 0.
REQ-015 m_wdata  out  64  data for the memory write.
REQ-016 m_rdata  in  64  memory read data, valid in the last cycle of a read.

Function
REQ-017 A write is accepted on the clock edge where c_write and c_wready are both high; the address and data are enqueued FIFO-ordered.
REQ-018 Write coalescing: if an accepted write's line address matches a queued entry that is not currently draining, that entry's data is overwritten in place and the occupancy count is unchanged.
REQ-019 c_wready = (count < DEPTH); a write arriving when full is not accepted, and no same-cycle dequeue bypass exists.
REQ-020 Read and write pointers wrap modulo DEPTH; count ranges from 0 to DEPTH.
REQ-021 The FSM has three states: IDLE, WRITE and READ.
REQ-022 IDLE transitions, in priority order:
  - c_read pending and the miss path applies -> READ;
  - otherwise count > 0 -> WRITE;
  - otherwise stay in IDLE.
REQ-023 WRITE: hold m_writeM=1 and the head entry's m_address/m_wdata for MEM_LATENCY cycles; on the last cycle, pop the head, decrement count, and return to IDLE.
REQ-024 READ: hold m_readM=1 and m_address=c_raddr line for MEM_LATENCY cycles; capture m_rdata on the last cycle; pulse c_rvalid in the following cycle; return to IDLE.
REQ-025 m_readM and m_writeM are never high in the same cycle.
REQ-026 A started WRITE or READ runs to completion; it is never aborted except by reset.
REQ-027 A read whose line matches any queued entry (including the draining head) is a buffer hit; its handling is set by the Configuration section.
REQ-028 If an accepted write and a hit on the same line occur in the same cycle, the read returns the newly written data.
REQ-029 Outputs idle at 0 when not driven by an active transaction.

Reset
REQ-030 reset immediately clears count, pointers and all entries, sets the FSM to IDLE, sets c_rvalid, m_readM and m_writeM to 0, and sets c_wready to 1.
REQ-031 Reset in the middle of a transaction discards it; no partial write is retried.

Configuration
REQ-032 Macro WB_READ_FORWARD_EN: when defined, a buffer hit returns the youngest matching entry's data with c_rvalid one cycle after c_read is sampled, and no memory access occurs.
REQ-033 When WB_READ_FORWARD_EN is undefined, a buffer hit blocks READ; the buffer drains WRITE transactions until no match remains, then performs READ from memory.

Verification
REQ-034 Scenario: write 0x0010/D0 then read 0x0020 with the buffer otherwise empty -> READ is taken first (m_readM for 4 cycles) and c_rvalid is pulsed; the WRITE of 0x0010 follows.
REQ-035 Scenario: fill 4 distinct lines -> c_wready=0; after the first drain completes, c_wready=1; the memory writes occur in enqueue order.
REQ-036 Scenario: write 0x0040/A then 0x0041/B before draining -> count stays at 1 and memory sees a single write of B to 0x0040.
REQ-037 Scenario: write 0x0080/C then read 0x0082:
  - with WB_READ_FORWARD_EN: c_rdata=C one cycle later, and m_readM stays 0;
  - without WB_READ_FORWARD_EN: the write drains, then a 4-cycle read occurs.
REQ-038 Scenario: assert reset on the second cycle of a WRITE -> m_writeM=0 immediately, count=0, and no further memory activity occurs.
